bus_initiator_6502: RTL and testbench
=====================================

Name: bus_initiator_6502

Overview:
- Drives the external 6502-style bus from the FPGA fabric as bus master.
- Generates a free-running PHI2 from the system clock and drives A, RW and D.
- Executes one read or write per bus cycle, taken from a valid/ready request port, and returns read data on a one-clock response strobe.
- Address decode and chip selects on the far side of the bus are gated by PHI2. Idle cycles are flagged on cycle_valid so downstream logic can suppress selects.

Parameters:
- PHI1_CYCLES, 4, clk cycles PHI2 is low per bus cycle; must be >= 2.
- PHI2_CYCLES, 4, clk cycles PHI2 is high per bus cycle; must be >= 1.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- req_valid  input  1  request present.
- req_ready  output  1  request holding slot empty.
- req_rw  input  1  1 = read, 0 = write.
- req_addr  input  16  transaction address.
- req_wdata  input  8  write data.
- rsp_valid  output  1  one-clk pulse: read data valid.
- rsp_rdata  output  8  read data captured from the bus.
- PHI2  output  1  bus phase-2 clock.
- RW  output  1  bus read/write, 1 = read.
- A  output  16  bus address.
- D_out  output  8  bus write data.
- D_oe  output  1  D_out tristate enable.
- D_in  input  8  bus read data.
- cycle_valid  output  1  current bus cycle carries a real transaction.

Behaviour:
- Terms:
  - T = PHI1_CYCLES + PHI2_CYCLES.
  - cnt = phase counter, 0..T-1, wraps T-1 -> 0 unconditionally.
- PHI2 (registered):
  - PHI2 = 1 exactly while cnt is in PHI1_CYCLES..T-1, else 0.
  - PHI2 falls on the edge entering cnt = 0.
  - PHI2 rises on the edge entering cnt = PHI1_CYCLES.
- Request slot (one entry):
  - Handshake occurs on an edge where req_valid && req_ready.
  - The captured rw/addr/wdata set pending = 1.
  - req_ready = !pending (registered). Upstream must hold the request stable while valid && !ready.
- Launch edge (cnt 0 -> 1), one clk after PHI2 falls, which provides address/data hold:
  - If pending, or a handshake occurs on this same edge (bypass), load A, RW and D_out from that request, set cycle_valid = 1 and clear pending.
  - Otherwise keep A and D_out at their last values and set RW = 1, cycle_valid = 0.
  - If pending and a new handshake coincide, the pending entry launches first and the new request becomes pending. req_ready is low in that case, so coincidence cannot occur; it is listed for completeness.
- D_oe:
  - Goes to 1 on the edge entering cnt = PHI1_CYCLES when cycle_valid && !RW.
  - Goes to 0 on the next launch edge, giving one clk of data hold after PHI2 falls.
  - D_oe is never 1 while RW = 1.
- Read capture:
  - On the edge entering cnt = 0 (PHI2 falling), if cycle_valid && RW, set rsp_rdata = D_in and rsp_valid = 1 for exactly the cnt = 0 clk.
  - rsp_rdata holds its value until the next read.
- Writes produce no response. Completion is implied by cycle order.
- Throughput:
  - At most one transaction per bus cycle.
  - Back-to-back requests run in consecutive bus cycles provided each is accepted before its launch edge.
- Reset (async, any cnt):
  - cnt = 0, PHI2 = 0, A = 16'hFFFF, RW = 1, D_out = 0, D_oe = 0, cycle_valid = 0, rsp_valid = 0, rsp_rdata = 0, pending = 0, req_ready = 1.
  - An in-flight transaction is dropped, with no response, and not replayed.
  - After reset deasserts, counting resumes from 0.

Test Plan:
- Free-run with defaults, no requests -> PHI2 period 8 clk, low 4 / high 4; cycle_valid = 0, RW = 1, A = FFFF, D_oe = 0 throughout.
- Read at addr 16'h8000 with D_in = 8'h5A modelled during PHI2 high -> A = 8000 and RW = 1 from the launch edge; rsp_valid pulses once at the next PHI2 fall; rsp_rdata = 5A.
- Write of 8'hC3 to 16'h0200 -> RW = 0 and A = 0200 from launch; D_oe high from PHI2 rise through one clk after PHI2 fall; D_out = C3; no rsp_valid.
- Three back-to-back requests (W 0010 = 11, R 0011, R 0012) with req_valid held -> three consecutive bus cycles, each with cycle_valid = 1; two rsp_valid pulses, one per read cycle; req_ready low while pending.
- Request presented exactly on the cnt 0 -> 1 edge with slot empty -> bypass launch in that same bus cycle; pending stays 0.
- Assert rst_n low during PHI2 high of a write -> immediately PHI2 = 0, D_oe = 0, RW = 1, A = FFFF, req_ready = 1; no response after release; next request runs normally.

Source files
------------

// File: rtl/bus_initiator_6502.sv
// ---------------------------------------------------------------------------
// bus_initiator_6502
//
// Bus master for an external 6502-style bus. The module derives a
// free-running PHI2 from the system clock and runs at most one read or write
// per bus cycle. Transactions come from a valid/ready request port that has a
// single holding slot. Read data is returned on a one-clock response strobe.
//
// One bus cycle is PHI1_CYCLES clocks with PHI2 low, followed by PHI2_CYCLES
// clocks with PHI2 high. Address, RW and write data change on the "launch"
// edge, one clock after PHI2 falls, so the far side gets one clock of hold.
//
// Ports
//   clk          system clock; all logic updates on its rising edge
//   rst_n        asynchronous active-low reset
//   req_valid    request present
//   req_ready    holding slot is empty
//   req_rw       request direction, 1 = read, 0 = write
//   req_addr     request address
//   req_wdata    request write data
//   rsp_valid    one-clock pulse: rsp_rdata holds new read data
//   rsp_rdata    read data captured from the bus on the PHI2 falling edge
//   PHI2         bus phase-2 clock
//   RW           bus read/write, 1 = read
//   A            bus address
//   D_out        bus write data
//   D_oe         tristate enable for D_out
//   D_in         bus read data
//   cycle_valid  current bus cycle carries a real transaction
// ---------------------------------------------------------------------------
module bus_initiator_6502 #(
  parameter int PHI1_CYCLES = 4,
  parameter int PHI2_CYCLES = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_rw,
  input  logic [15:0] req_addr,
  input  logic [7:0]  req_wdata,
  output logic        rsp_valid,
  output logic [7:0]  rsp_rdata,
  output logic        PHI2,
  output logic        RW,
  output logic [15:0] A,
  output logic [7:0]  D_out,
  output logic        D_oe,
  input  logic [7:0]  D_in,
  output logic        cycle_valid
);

  localparam int T  = PHI1_CYCLES + PHI2_CYCLES;
  localparam int CW = (T > 1) ? $clog2(T) : 1;

  // Phase-counter values that identify each edge of interest. The value
  // named here is the count *before* the edge.
  localparam logic [CW-1:0] CNT_LAUNCH   = '0;                  // 0 -> 1
  localparam logic [CW-1:0] CNT_RISE_PRE = CW'(PHI1_CYCLES - 1); // -> PHI1_CYCLES
  localparam logic [CW-1:0] CNT_LAST     = CW'(T - 1);           // -> 0
  localparam logic [CW-1:0] CNT_PHI2_LO  = CW'(PHI1_CYCLES);

  // -------------------------------------------------------------------------
  // Phase counter and PHI2
  // -------------------------------------------------------------------------
  logic [CW-1:0] r_cnt;
  logic [CW-1:0] w_cnt_next;
  logic          w_phi2_next;
  logic          r_phi2;

  assign w_cnt_next  = (r_cnt == CNT_LAST) ? '0 : r_cnt + 1'b1;
  // PHI2 is registered and decoded from the count being entered, so it lines
  // up exactly with cnt in PHI1_CYCLES..T-1.
  assign w_phi2_next = (w_cnt_next >= CNT_PHI2_LO);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt  <= '0;
      r_phi2 <= 1'b0;
    end else begin
      r_cnt  <= w_cnt_next;
      r_phi2 <= w_phi2_next;
    end
  end

  logic w_launch_edge;
  logic w_rise_edge;
  logic w_fall_edge;

  assign w_launch_edge = (r_cnt == CNT_LAUNCH);
  assign w_rise_edge   = (r_cnt == CNT_RISE_PRE);
  assign w_fall_edge   = (r_cnt == CNT_LAST);

  // -------------------------------------------------------------------------
  // Request holding slot
  // -------------------------------------------------------------------------
  logic        r_pending;
  logic        r_pend_rw;
  logic [15:0] r_pend_addr;
  logic [7:0]  r_pend_wdata;

  logic w_handshake;
  logic w_launch_pending;
  logic w_launch_bypass;
  logic w_capture;

  // Ready is the inverse of a register, so it carries no combinational path
  // from any input.
  assign req_ready   = !r_pending;
  assign w_handshake = req_valid && !r_pending;

  // A pending entry always launches before anything newly accepted. With an
  // empty slot, a request accepted on the launch edge goes straight onto the
  // bus and never occupies the slot.
  assign w_launch_pending = w_launch_edge && r_pending;
  assign w_launch_bypass  = w_launch_edge && !r_pending && w_handshake;
  assign w_capture        = w_handshake && !w_launch_bypass;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pending    <= 1'b0;
      r_pend_rw    <= 1'b1;
      r_pend_addr  <= 16'hFFFF;
      r_pend_wdata <= 8'h00;
    end else begin
      if (w_launch_pending) begin
        r_pending <= 1'b0;
      end
      // Capture comes last so a (theoretical) coincidence with a pending
      // launch leaves the new request pending.
      if (w_capture) begin
        r_pending    <= 1'b1;
        r_pend_rw    <= req_rw;
        r_pend_addr  <= req_addr;
        r_pend_wdata <= req_wdata;
      end
    end
  end

  // -------------------------------------------------------------------------
  // Launch mux: slot contents when pending, otherwise the live request
  // -------------------------------------------------------------------------
  logic        w_do_launch;
  logic        w_sel_rw;
  logic [15:0] w_sel_addr;
  logic [7:0]  w_sel_wdata;

  assign w_do_launch = w_launch_pending || w_launch_bypass;
  assign w_sel_rw    = r_pending ? r_pend_rw    : req_rw;
  assign w_sel_addr  = r_pending ? r_pend_addr  : req_addr;
  assign w_sel_wdata = r_pending ? r_pend_wdata : req_wdata;

  // -------------------------------------------------------------------------
  // Bus address / direction / data
  // -------------------------------------------------------------------------
  logic        r_rw;
  logic [15:0] r_addr;
  logic [7:0]  r_dout;
  logic        r_cycle_valid;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rw          <= 1'b1;
      r_addr        <= 16'hFFFF;
      r_dout        <= 8'h00;
      r_cycle_valid <= 1'b0;
    end else if (w_launch_edge) begin
      if (w_do_launch) begin
        r_rw          <= w_sel_rw;
        r_addr        <= w_sel_addr;
        r_dout        <= w_sel_wdata;
        r_cycle_valid <= 1'b1;
      end else begin
        // Idle cycle: A and D_out keep their last values to avoid needless
        // toggling; RW parks at read so nothing on the bus gets written.
        r_rw          <= 1'b1;
        r_cycle_valid <= 1'b0;
      end
    end
  end

  // -------------------------------------------------------------------------
  // Data output enable: from PHI2 rise until one clock after PHI2 falls
  // -------------------------------------------------------------------------
  logic r_doe;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_doe <= 1'b0;
    end else if (w_launch_edge) begin
      r_doe <= 1'b0;
    end else if (w_rise_edge && r_cycle_valid && !r_rw) begin
      r_doe <= 1'b1;
    end
  end

  // -------------------------------------------------------------------------
  // Read capture on the PHI2 falling edge
  // -------------------------------------------------------------------------
  logic       r_rsp_valid;
  logic [7:0] r_rsp_rdata;
  logic       w_read_done;

  assign w_read_done = w_fall_edge && r_cycle_valid && r_rw;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rsp_valid <= 1'b0;
      r_rsp_rdata <= 8'h00;
    end else begin
      r_rsp_valid <= w_read_done;
      if (w_read_done) begin
        r_rsp_rdata <= D_in;
      end
    end
  end

  // -------------------------------------------------------------------------
  // Outputs
  // -------------------------------------------------------------------------
  assign PHI2        = r_phi2;
  assign RW          = r_rw;
  assign A           = r_addr;
  assign D_out       = r_dout;
  assign D_oe        = r_doe;
  assign cycle_valid = r_cycle_valid;
  assign rsp_valid   = r_rsp_valid;
  assign rsp_rdata   = r_rsp_rdata;

endmodule

// File: tb/tb_bus_initiator_6502.sv
// ---------------------------------------------------------------------------
// tb_bus_initiator_6502
//
// Directed steps followed by random traffic. A bus-cycle level reference
// model (request queue + phase position) predicts every output; the external
// device is a combinational memory whose data is a function of the address.
// ---------------------------------------------------------------------------
module tb_bus_initiator_6502;

  localparam int P1 = 4;
  localparam int P2 = 4;
  localparam int T  = P1 + P2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_rw = 1'b1;
  logic [15:0] req_addr = 16'h0000;
  logic [7:0]  req_wdata = 8'h00;
  logic [7:0]  junk = 8'h00;

  logic        req_ready;
  logic        rsp_valid;
  logic [7:0]  rsp_rdata;
  logic        PHI2;
  logic        RW;
  logic [15:0] A;
  logic [7:0]  D_out;
  logic        D_oe;
  logic [7:0]  D_in;
  logic        cycle_valid;

  always #5 clk = ~clk;

  bus_initiator_6502 #(.PHI1_CYCLES(P1), .PHI2_CYCLES(P2)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_rw      (req_rw),
    .req_addr    (req_addr),
    .req_wdata   (req_wdata),
    .rsp_valid   (rsp_valid),
    .rsp_rdata   (rsp_rdata),
    .PHI2        (PHI2),
    .RW          (RW),
    .A           (A),
    .D_out       (D_out),
    .D_oe        (D_oe),
    .D_in        (D_in),
    .cycle_valid (cycle_valid)
  );

  // External device: drives valid data only while PHI2 is high.
  function automatic logic [7:0] fmem(input logic [15:0] a);
    return a[7:0] ^ a[15:8] ^ 8'hDA;
  endfunction

  assign D_in = PHI2 ? fmem(A) : junk;

  int checks = 0;
  int failures = 0;
  int rsp_seen = 0;

  // ---------------- reference model ----------------
  typedef struct {
    logic        rw;
    logic [15:0] addr;
    logic [7:0]  wdata;
  } req_t;

  req_t        slot_q[$];
  int          m_cnt;
  logic        m_phi2, m_RW, m_oe, m_cv, m_rv;
  logic [15:0] m_A;
  logic [7:0]  m_Dout, m_rdata;
  bit          m_hs;

  task automatic model_reset();
    slot_q.delete();
    m_cnt = 0; m_phi2 = 1'b0; m_A = 16'hFFFF; m_RW = 1'b1; m_Dout = 8'h00;
    m_oe = 1'b0; m_cv = 1'b0; m_rv = 1'b0; m_rdata = 8'h00; m_hs = 1'b0;
  endtask

  task automatic model_launch(input req_t t);
    m_A = t.addr; m_RW = t.rw; m_Dout = t.wdata; m_cv = 1'b1;
  endtask

  // Advance the model across one rising edge, using the inputs held there.
  task automatic model_edge();
    req_t nr;
    bit   hs;
    bit   used;
    int   pos;
    pos  = m_cnt;
    hs   = req_valid && (slot_q.size() == 0);
    used = 1'b0;
    nr.rw = req_rw; nr.addr = req_addr; nr.wdata = req_wdata;
    if (pos == 0) begin
      m_oe = 1'b0;
      if (slot_q.size() > 0) begin
        model_launch(slot_q.pop_front());
      end else if (hs) begin
        model_launch(nr);
        used = 1'b1;
      end else begin
        m_RW = 1'b1;
        m_cv = 1'b0;
      end
    end
    if (hs && !used) slot_q.push_back(nr);
    if (pos == P1 - 1 && m_cv && !m_RW) m_oe = 1'b1;
    m_rv = 1'b0;
    if (pos == T - 1 && m_cv && m_RW) begin
      m_rv = 1'b1;
      m_rdata = fmem(m_A);
    end
    m_cnt  = (pos + 1) % T;
    m_phi2 = (m_cnt >= P1);
    m_hs   = hs;
  endtask

  // ---------------- checking ----------------
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    chk("phi2",        32'(PHI2),        32'(m_phi2));
    chk("addr",        32'(A),           32'(m_A));
    chk("rw",          32'(RW),          32'(m_RW));
    chk("d_out",       32'(D_out),       32'(m_Dout));
    chk("d_oe",        32'(D_oe),        32'(m_oe));
    chk("cycle_valid", 32'(cycle_valid), 32'(m_cv));
    chk("rsp_valid",   32'(rsp_valid),   32'(m_rv));
    chk("rsp_rdata",   32'(rsp_rdata),   32'(m_rdata));
    chk("req_ready",   32'(req_ready),   32'(slot_q.size() == 0));
    chk("oe_while_rd", 32'(D_oe && RW),  32'(0));
  endtask

  // One clock: model steps on the rising edge, outputs checked on the falling.
  task automatic tick();
    @(posedge clk);
    if (rst_n) model_edge();
    @(negedge clk);
    check_all();
    if (rsp_valid) rsp_seen++;
    junk = 8'($urandom);
  endtask

  // Present a request and hold it until accepted (bounded).
  task automatic send(input logic rw, input logic [15:0] a, input logic [7:0] d);
    bit ok;
    ok = 1'b0;
    req_rw = rw; req_addr = a; req_wdata = d; req_valid = 1'b1;
    for (int i = 0; i < 5 * T; i++) begin
      tick();
      if (m_hs) begin
        ok = 1'b1;
        break;
      end
    end
    req_valid = 1'b0;
    req_addr  = 16'($urandom);
    req_wdata = 8'($urandom);
    chk("accept", 32'(ok), 32'(1));
    $display("txn %s addr=%04h wdata=%02h accepted=%0d", rw ? "RD" : "WR", a, d, ok);
  endtask

  initial begin
    int  base;
    bit  found;

    // Reset state
    model_reset();
    @(negedge clk);
    check_all();
    repeat (2) tick();
    rst_n = 1'b1;

    // Free run, no requests
    repeat (3 * T) tick();

    // Single read
    send(1'b1, 16'h8000, 8'h00);
    repeat (2 * T) tick();
    chk("read_8000_data", 32'(rsp_rdata), 32'(8'h5A));

    // Single write
    send(1'b0, 16'h0200, 8'hC3);
    repeat (2 * T) tick();
    chk("write_d_out", 32'(D_out), 32'(8'hC3));

    // Three back-to-back requests
    base = rsp_seen;
    send(1'b0, 16'h0010, 8'h11);
    send(1'b1, 16'h0011, 8'h00);
    send(1'b1, 16'h0012, 8'h00);
    repeat (3 * T) tick();
    chk("b2b_rsp_count", 32'(rsp_seen - base), 32'(2));

    // Bypass: request appears exactly at the launch edge with the slot empty
    found = 1'b0;
    for (int i = 0; i < 3 * T; i++) begin
      if (m_cnt == 0 && slot_q.size() == 0) begin
        found = 1'b1;
        break;
      end
      tick();
    end
    chk("bypass_found", 32'(found), 32'(1));
    req_rw = 1'b1; req_addr = 16'h4321; req_wdata = 8'h00; req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
    $display("txn RD addr=4321 bypass");
    chk("bypass_ready", 32'(req_ready), 32'(1));
    chk("bypass_cv",    32'(cycle_valid), 32'(1));
    chk("bypass_addr",  32'(A), 32'(16'h4321));
    repeat (2 * T) tick();

    // Reset during PHI2 high of a write
    send(1'b0, 16'h1234, 8'h77);
    found = 1'b0;
    for (int i = 0; i < 3 * T; i++) begin
      if (m_cv && !m_RW && m_phi2) begin
        found = 1'b1;
        break;
      end
      tick();
    end
    chk("write_phi2_found", 32'(found), 32'(1));
    chk("write_oe_before_rst", 32'(D_oe), 32'(1));
    rst_n = 1'b0;
    model_reset();
    #1;
    check_all();
    repeat (2) tick();
    rst_n = 1'b1;
    base = rsp_seen;
    repeat (2 * T) tick();
    chk("no_rsp_after_rst", 32'(rsp_seen - base), 32'(0));
    send(1'b1, 16'h00FE, 8'h00);
    repeat (2 * T) tick();
    chk("read_after_rst", 32'(rsp_rdata), 32'(fmem(16'h00FE)));

    // Random traffic
    for (int n = 0; n < 120; n++) begin
      send(1'($urandom), 16'($urandom), 8'($urandom));
      repeat ($urandom_range(0, 3)) tick();
    end
    repeat (3 * T) tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Watchdog so the run always terminates.
  initial begin
    #2000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
